// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the CPU/DMA memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DMA
  } requester_t;

  localparam int unsigned MAX_WAIT_STATES = 7;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT_STATES + 1);

  // Clamp a requested wait-state count into the counter's range.
  function automatic logic [WAIT_W-1:0] clamp_wait(input int unsigned ws);
    if (ws > MAX_WAIT_STATES) begin
      return WAIT_W'(MAX_WAIT_STATES);
    end
    return WAIT_W'(ws);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: the requester that did not win last time wins a tie.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_cpu,
  input  logic       req_dma,
  input  logic       advance,
  output requester_t winner
);

  requester_t last_grant_q;

  always_comb begin
    winner = REQ_DMA;
    if (req_cpu && req_dma) begin
      if (last_grant_q == REQ_DMA) begin
        winner = REQ_CPU;
      end else begin
        winner = REQ_DMA;
      end
    end else if (req_cpu) begin
      winner = REQ_CPU;
    end
  end

  // Reset to DMA so the CPU takes the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_DMA;
    end else if (advance) begin
      last_grant_q <= winner;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous single-port RAM between the CPU and a read-only DMA port.
// Handshake: a requester holds addr/data/request until it sees its one-cycle ready pulse.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] ROM_BASE    = 16'hE000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic [15:0] dma_addr,
  input  logic        dma_read,
  output logic [7:0]  dma_rdata,
  output logic        dma_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        grant_cpu,
  output logic        busy,
  output arb_state_t  state_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = clamp_wait(WAIT_STATES);

  arb_state_t        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              grant_cpu_q;
  logic              is_write_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [15:0]       ram_addr_q;
  logic [7:0]        ram_wdata_q;
  logic              cpu_ready_q;
  logic              dma_ready_q;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        dma_rdata_q;

  logic       cpu_req;
  logic       dma_req;
  logic       advance;
  logic       pick_cpu;
  requester_t winner;

  assign cpu_req  = cpu_read | cpu_write;
  assign dma_req  = dma_read;
  assign advance  = (state_q == IDLE) && (cpu_req || dma_req);
  assign pick_cpu = (winner == REQ_CPU);

  arb_rr2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_cpu (cpu_req),
    .req_dma (dma_req),
    .advance (advance),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      grant_cpu_q <= 1'b0;
      is_write_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (advance) begin
            // A CPU read+write pair is a write; writes into the ROM window never strobe we.
            grant_cpu_q <= pick_cpu;
            is_write_q  <= pick_cpu & cpu_write;
            ram_addr_q  <= pick_cpu ? cpu_addr : dma_addr;
            ram_wdata_q <= pick_cpu ? cpu_wdata : 8'h00;
            ram_we_q    <= pick_cpu & cpu_write & (cpu_addr < ROM_BASE);
            ram_en_q    <= 1'b1;
            wait_q      <= WAIT_LOAD;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_q == '0) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            cpu_ready_q <= grant_cpu_q;
            dma_ready_q <= ~grant_cpu_q;
            state_q     <= DONE;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        DONE: begin
          if (grant_cpu_q && !is_write_q) begin
            cpu_rdata_q <= ram_rdata;
          end
          if (!grant_cpu_q) begin
            dma_rdata_q <= ram_rdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is bypassed during the ready cycle so it is visible with the pulse.
  assign cpu_rdata = (cpu_ready_q && !is_write_q) ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = dma_ready_q ? ram_rdata : dma_rdata_q;

  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign grant_cpu = grant_cpu_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with no wait states, one with two.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance with WAIT_STATES = 0 ----------------
  logic [15:0] d0_cpu_addr = '0;
  logic [7:0]  d0_cpu_wdata = '0;
  logic        d0_cpu_read = 1'b0;
  logic        d0_cpu_write = 1'b0;
  logic [7:0]  d0_cpu_rdata;
  logic        d0_cpu_ready;
  logic [15:0] d0_dma_addr = '0;
  logic        d0_dma_read = 1'b0;
  logic [7:0]  d0_dma_rdata;
  logic        d0_dma_ready;
  logic        d0_ram_en;
  logic        d0_ram_we;
  logic [15:0] d0_ram_addr;
  logic [7:0]  d0_ram_wdata;
  logic [7:0]  d0_ram_rdata = '0;
  logic        d0_grant_cpu;
  logic        d0_busy;
  arb_state_t  d0_state;
  logic [7:0]  mem0 [65536];

  // ---------------- instance with WAIT_STATES = 2 ----------------
  logic [15:0] d2_cpu_addr = '0;
  logic [7:0]  d2_cpu_wdata = '0;
  logic        d2_cpu_read = 1'b0;
  logic        d2_cpu_write = 1'b0;
  logic [7:0]  d2_cpu_rdata;
  logic        d2_cpu_ready;
  logic [15:0] d2_dma_addr = '0;
  logic        d2_dma_read = 1'b0;
  logic [7:0]  d2_dma_rdata;
  logic        d2_dma_ready;
  logic        d2_ram_en;
  logic        d2_ram_we;
  logic [15:0] d2_ram_addr;
  logic [7:0]  d2_ram_wdata;
  logic [7:0]  d2_ram_rdata = '0;
  logic        d2_grant_cpu;
  logic        d2_busy;
  arb_state_t  d2_state;
  logic [7:0]  mem2 [65536];

  mem_bus_arbiter #(.WAIT_STATES(0), .ROM_BASE(16'hE000)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_addr(d0_cpu_addr), .cpu_wdata(d0_cpu_wdata), .cpu_read(d0_cpu_read),
    .cpu_write(d0_cpu_write), .cpu_rdata(d0_cpu_rdata), .cpu_ready(d0_cpu_ready),
    .dma_addr(d0_dma_addr), .dma_read(d0_dma_read), .dma_rdata(d0_dma_rdata),
    .dma_ready(d0_dma_ready), .ram_en(d0_ram_en), .ram_we(d0_ram_we),
    .ram_addr(d0_ram_addr), .ram_wdata(d0_ram_wdata), .ram_rdata(d0_ram_rdata),
    .grant_cpu(d0_grant_cpu), .busy(d0_busy), .state_dbg(d0_state)
  );

  mem_bus_arbiter #(.WAIT_STATES(2), .ROM_BASE(16'hE000)) u_dut2 (
    .clk(clk), .rst(rst),
    .cpu_addr(d2_cpu_addr), .cpu_wdata(d2_cpu_wdata), .cpu_read(d2_cpu_read),
    .cpu_write(d2_cpu_write), .cpu_rdata(d2_cpu_rdata), .cpu_ready(d2_cpu_ready),
    .dma_addr(d2_dma_addr), .dma_read(d2_dma_read), .dma_rdata(d2_dma_rdata),
    .dma_ready(d2_dma_ready), .ram_en(d2_ram_en), .ram_we(d2_ram_we),
    .ram_addr(d2_ram_addr), .ram_wdata(d2_ram_wdata), .ram_rdata(d2_ram_rdata),
    .grant_cpu(d2_grant_cpu), .busy(d2_busy), .state_dbg(d2_state)
  );

  // ---------------- clock and RAM models ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (d0_ram_en) begin
      if (d0_ram_we) mem0[d0_ram_addr] <= d0_ram_wdata;
      d0_ram_rdata <= mem0[d0_ram_addr];
    end
    if (d2_ram_en) begin
      if (d2_ram_we) mem2[d2_ram_addr] <= d2_ram_wdata;
      d2_ram_rdata <= mem2[d2_ram_addr];
    end
  end

  // Inputs change and outputs are sampled on the falling edge; cycle c is
  // the period after the c-th rising edge following stimulus.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if ({d0_cpu_ready, d0_dma_ready, d0_ram_en, d0_ram_we, d0_grant_cpu, d0_busy} !== 6'b0) begin
      $display("FAIL reset.d0_ctrl got %b exp 000000", {d0_cpu_ready, d0_dma_ready, d0_ram_en, d0_ram_we, d0_grant_cpu, d0_busy});
    end else n_pass++;
    n_checks++;
    if ({d0_cpu_rdata, d0_dma_rdata, d0_ram_addr, d0_ram_wdata} !== 40'h0) begin
      $display("FAIL reset.d0_data got %h exp 0", {d0_cpu_rdata, d0_dma_rdata, d0_ram_addr, d0_ram_wdata});
    end else n_pass++;
    n_checks++;
    if (d0_state !== IDLE) begin
      $display("FAIL reset.d0_state got %0d exp %0d", d0_state, IDLE);
    end else n_pass++;
    n_checks++;
    if ({d2_cpu_ready, d2_dma_ready, d2_ram_en, d2_busy, d2_grant_cpu} !== 5'b0) begin
      $display("FAIL reset.d2_ctrl got %b exp 00000", {d2_cpu_ready, d2_dma_ready, d2_ram_en, d2_busy, d2_grant_cpu});
    end else n_pass++;
    n_checks++;
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    mem0[16'h0200] = 8'h5A;
    d0_cpu_addr = 16'h0200;
    d0_cpu_read = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (d0_ram_en !== (c == 1)) begin
        $display("FAIL cpu_read.ram_en c=%0d got %b exp %b", c, d0_ram_en, (c == 1));
      end else n_pass++;
      n_checks++;
      if (d0_cpu_ready !== (c == 2)) begin
        $display("FAIL cpu_read.cpu_ready c=%0d got %b exp %b", c, d0_cpu_ready, (c == 2));
      end else n_pass++;
      n_checks++;
      if (d0_dma_ready !== 1'b0) begin
        $display("FAIL cpu_read.dma_ready c=%0d got %b exp 0", c, d0_dma_ready);
      end else n_pass++;
      n_checks++;
      if (c == 1 && d0_ram_addr !== 16'h0200) begin
        $display("FAIL cpu_read.ram_addr got %h exp 0200", d0_ram_addr);
      end else if (c == 1) n_pass++;
      if (c == 1) n_checks++;
      if (c >= 2 && d0_cpu_rdata !== 8'h5A) begin
        $display("FAIL cpu_read.cpu_rdata c=%0d got %h exp 5a", c, d0_cpu_rdata);
      end else if (c >= 2) n_pass++;
      if (c >= 2) n_checks++;
      if (c == 2) d0_cpu_read = 1'b0;
    end
    if (d0_busy !== 1'b0) begin
      $display("FAIL cpu_read.busy_idle got %b exp 0", d0_busy);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_tie();
    logic exp_cr, exp_dr, exp_en;
    do_reset();
    mem0[16'h0010] = 8'hA1;
    mem0[16'h8000] = 8'hB2;
    d0_cpu_addr = 16'h0010;
    d0_dma_addr = 16'h8000;
    d0_cpu_read = 1'b1;
    d0_dma_read = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_cr = (c == 2) || (c == 8);
      exp_dr = (c == 5);
      exp_en = (c == 1) || (c == 4) || (c == 7);
      if ({d0_cpu_ready, d0_dma_ready, d0_ram_en} !== {exp_cr, exp_dr, exp_en}) begin
        $display("FAIL tie.ready_en c=%0d got %b exp %b", c, {d0_cpu_ready, d0_dma_ready, d0_ram_en}, {exp_cr, exp_dr, exp_en});
      end else n_pass++;
      n_checks++;
      if (exp_en) begin
        if ({d0_grant_cpu, d0_ram_addr} !== ((c == 4) ? {1'b0, 16'h8000} : {1'b1, 16'h0010})) begin
          $display("FAIL tie.grant c=%0d got %b/%h", c, d0_grant_cpu, d0_ram_addr);
        end else n_pass++;
        n_checks++;
      end
      if (c == 2 && d0_cpu_rdata !== 8'hA1) begin
        $display("FAIL tie.cpu_rdata got %h exp a1", d0_cpu_rdata);
      end else if (c == 2) n_pass++;
      if (c == 2) n_checks++;
      if (c == 5 && d0_dma_rdata !== 8'hB2) begin
        $display("FAIL tie.dma_rdata got %h exp b2", d0_dma_rdata);
      end else if (c == 5) n_pass++;
      if (c == 5) n_checks++;
      if (c == 8) begin
        d0_cpu_read = 1'b0;
        d0_dma_read = 1'b0;
      end
    end
  endtask

  task automatic test_wait_states();
    mem2[16'h1234] = 8'hC3;
    d2_dma_addr = 16'h1234;
    d2_dma_read = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if ({d2_ram_en, d2_dma_ready, d2_busy, d2_cpu_ready} !== {(c <= 3), (c == 4), (c <= 4), 1'b0}) begin
        $display("FAIL wait.en_ready_busy c=%0d got %b exp %b", c, {d2_ram_en, d2_dma_ready, d2_busy, d2_cpu_ready}, {(c <= 3), (c == 4), (c <= 4), 1'b0});
      end else n_pass++;
      n_checks++;
      if (c >= 4 && d2_dma_rdata !== 8'hC3) begin
        $display("FAIL wait.dma_rdata c=%0d got %h exp c3", c, d2_dma_rdata);
      end else if (c >= 4) n_pass++;
      if (c >= 4) n_checks++;
      if (c == 4) d2_dma_read = 1'b0;
    end
  endtask

  task automatic test_protected_write();
    mem0[16'hE000] = 8'h77;
    mem0[16'hDFFF] = 8'h00;
    d0_cpu_addr  = 16'hE000;
    d0_cpu_wdata = 8'hFF;
    d0_cpu_write = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if ({d0_ram_we, d0_ram_en, d0_cpu_ready} !== {1'b0, (c == 1), (c == 2)}) begin
        $display("FAIL prot.we_en_ready c=%0d got %b exp %b", c, {d0_ram_we, d0_ram_en, d0_cpu_ready}, {1'b0, (c == 1), (c == 2)});
      end else n_pass++;
      n_checks++;
      if (c == 2) d0_cpu_write = 1'b0;
    end
    d0_cpu_read = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        if ({d0_cpu_ready, d0_cpu_rdata} !== {1'b1, 8'h77}) begin
          $display("FAIL prot.readback got %b/%h exp 1/77", d0_cpu_ready, d0_cpu_rdata);
        end else n_pass++;
        n_checks++;
        d0_cpu_read = 1'b0;
      end
    end
    d0_cpu_addr  = 16'hDFFF;
    d0_cpu_write = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (d0_ram_we !== (c == 1)) begin
        $display("FAIL edge.ram_we c=%0d got %b exp %b", c, d0_ram_we, (c == 1));
      end else n_pass++;
      n_checks++;
      if (c == 1 && d0_ram_wdata !== 8'hFF) begin
        $display("FAIL edge.ram_wdata got %h exp ff", d0_ram_wdata);
      end else if (c == 1) n_pass++;
      if (c == 1) n_checks++;
      if (c == 2) d0_cpu_write = 1'b0;
    end
    if ({mem0[16'hE000], mem0[16'hDFFF]} !== {8'h77, 8'hFF}) begin
      $display("FAIL prot.ram_contents got %h/%h exp 77/ff", mem0[16'hE000], mem0[16'hDFFF]);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_read_write_both();
    mem0[16'h0300] = 8'h00;
    d0_cpu_addr  = 16'h0300;
    d0_cpu_wdata = 8'h11;
    d0_cpu_read  = 1'b1;
    d0_cpu_write = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if ({d0_ram_we, d0_cpu_ready} !== {(c == 1), (c == 2)}) begin
        $display("FAIL both.we_ready c=%0d got %b exp %b", c, {d0_ram_we, d0_cpu_ready}, {(c == 1), (c == 2)});
      end else n_pass++;
      n_checks++;
      if (c >= 2 && d0_cpu_rdata !== 8'h77) begin
        $display("FAIL both.cpu_rdata c=%0d got %h exp 77", c, d0_cpu_rdata);
      end else if (c >= 2) n_pass++;
      if (c >= 2) n_checks++;
      if (c == 2) begin
        d0_cpu_read  = 1'b0;
        d0_cpu_write = 1'b0;
      end
    end
    if (mem0[16'h0300] !== 8'h11) begin
      $display("FAIL both.ram_contents got %h exp 11", mem0[16'h0300]);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    mem0[16'h0400] = 8'h00;
    d0_cpu_addr  = 16'h0400;
    d0_cpu_wdata = 8'h55;
    d0_cpu_write = 1'b1;
    @(negedge clk);
    if ({d0_ram_en, d0_ram_we, d0_cpu_rdata} !== {2'b11, 8'h77}) begin
      $display("FAIL rstmid.pre got %b%b/%h exp 11/77", d0_ram_en, d0_ram_we, d0_cpu_rdata);
    end else n_pass++;
    n_checks++;
    #1 rst = 1'b1;
    #1;
    if ({d0_ram_en, d0_ram_we, d0_busy, d0_cpu_rdata} !== 11'h0) begin
      $display("FAIL rstmid.async got %b%b%b/%h exp 000/00", d0_ram_en, d0_ram_we, d0_busy, d0_cpu_rdata);
    end else n_pass++;
    n_checks++;
    d0_cpu_write = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if ({d0_cpu_ready, d0_dma_ready, d0_ram_en} !== 3'b0) begin
        $display("FAIL rstmid.no_ready c=%0d got %b exp 000", c, {d0_cpu_ready, d0_dma_ready, d0_ram_en});
      end else n_pass++;
      n_checks++;
    end
    rst = 1'b0;
    if (mem0[16'h0400] !== 8'h00) begin
      $display("FAIL rstmid.no_write got %h exp 00", mem0[16'h0400]);
    end else n_pass++;
    n_checks++;
    d0_cpu_addr = 16'h0010;
    d0_dma_addr = 16'h8000;
    d0_cpu_read = 1'b1;
    d0_dma_read = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 1 && {d0_grant_cpu, d0_ram_addr} !== {1'b1, 16'h0010}) begin
        $display("FAIL rstmid.tie_grant got %b/%h exp 1/0010", d0_grant_cpu, d0_ram_addr);
      end else if (c == 1) n_pass++;
      if (c == 1) n_checks++;
      if (c == 2 && {d0_cpu_ready, d0_dma_ready, d0_cpu_rdata} !== {2'b10, 8'hA1}) begin
        $display("FAIL rstmid.tie_ready got %b%b/%h exp 10/a1", d0_cpu_ready, d0_dma_ready, d0_cpu_rdata);
      end else if (c == 2) n_pass++;
      if (c == 2) n_checks++;
    end
    d0_cpu_read = 1'b0;
    d0_dma_read = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_tie();
    test_wait_states();
    test_protected_write();
    test_read_write_both();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
